// File: rtl/pattern_detector_pkg.sv
// Shared definitions for the serial pattern detector: status codes driven on y
// and a helper that turns detector state into a status code.
package pattern_detector_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FILL  = 2'b01,
        ARMED = 2'b10,
        MATCH = 2'b11
    } status_t;

    // A match always wins; otherwise the status reflects how full the history is.
    function automatic status_t status_of(input logic hit, input logic empty, input logic full);
        status_t s;
        if (hit) begin
            s = MATCH;
        end else if (empty) begin
            s = IDLE;
        end else if (full) begin
            s = ARMED;
        end else begin
            s = FILL;
        end
        return s;
    endfunction

endpackage

// File: rtl/pattern_detector_sat_counter.sv
// Saturating up-counter with synchronous clear; sat flags the all-ones value.
module sat_counter
    import pattern_detector_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count_plus;

    assign count_plus = count + CNT_W'(1);

    // Clear beats increment; once at the maximum the counter simply holds.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count_plus;
            sat   <= (count_plus == CNT_MAX);
        end
    end

endmodule

// File: rtl/pattern_detector.sv
// Serial pattern detector: shifts enabled bits into a history register, flags a
// registered one-cycle match when the newest PATTERN_W bits equal PATTERN, and
// counts matches in a saturating counter.
module pattern_detector
    import pattern_detector_pkg::*;
#(
    parameter int                   PATTERN_W = 4,
    parameter logic [PATTERN_W-1:0] PATTERN   = 4'b0110,
    parameter int                   CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             x,
    input  logic             ovl_mode,
    input  logic             clr_cnt,
    output logic [1:0]       y,
    output logic             match,
    output logic [CNT_W-1:0] count,
    output logic             cnt_sat
);

    localparam int                FILL_W    = $clog2(PATTERN_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_W);

    logic [PATTERN_W-1:0] history;
    logic [PATTERN_W-1:0] history_next;
    logic [PATTERN_W-1:0] shifted;
    logic [FILL_W-1:0]    fill;
    logic [FILL_W-1:0]    fill_inc;
    logic [FILL_W-1:0]    fill_next;
    logic                 hit;
    status_t              status_q;
    status_t              status_next;

    // Work out the effect of this edge: new history, new fill and whether it completes a match.
    always_comb begin
        shifted      = {history[PATTERN_W-2:0], x};
        fill_inc     = (fill == FILL_FULL) ? FILL_FULL : fill + FILL_W'(1);
        history_next = history;
        fill_next    = fill;
        hit          = 1'b0;
        if (en) begin
            history_next = shifted;
            hit          = (fill_inc == FILL_FULL) && (shifted == PATTERN);
            fill_next    = (hit && !ovl_mode) ? '0 : fill_inc;
        end
        status_next = status_of(hit, fill_next == '0, fill_next == FILL_FULL);
    end

    // Register history, fill, the match pulse and the status code.
    always_ff @(posedge clk) begin
        if (rst) begin
            history  <= '0;
            fill     <= '0;
            match    <= 1'b0;
            status_q <= IDLE;
        end else begin
            history  <= history_next;
            fill     <= fill_next;
            match    <= hit;
            status_q <= status_next;
        end
    end

    assign y = status_q;

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_sat_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr_cnt),
        .inc  (hit),
        .count(count),
        .sat  (cnt_sat)
    );

endmodule

// File: doc/pattern_detector.md
PATTERN_DETECTOR -- requirements
Module: pattern_detector

Interface
REQ-001 SHALL have parameter PATTERN_W, default 4, serial pattern length in bits (legal 2..16).
REQ-002 SHALL have parameter PATTERN, default 4'b0110, target pattern, MSB is first bit received.
REQ-003 SHALL have parameter CNT_W, default 8, match-counter width (legal 1..16).
REQ-004 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port en  input  1  sample enable, x sampled only when en=1.
REQ-007 SHALL have port x  input  1  serial data bit.
REQ-008 SHALL have port ovl_mode  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-009 SHALL have port clr_cnt  input  1  synchronous clear of count and cnt_sat.
REQ-010 SHALL have port y  output  2  registered status code (see REQ-016).
REQ-011 SHALL have port match  output  1  registered one-cycle match pulse.
REQ-012 SHALL have port count  output  CNT_W  saturating number of matches.
REQ-013 SHALL have port cnt_sat  output  1  high while count is at its maximum value.

Function
REQ-014 SHALL shift x into a PATTERN_W-bit history register on each rising edge with en=1; history SHALL hold when en=0.
REQ-015 SHALL keep fill counter fill = number of valid bits in history, 0..PATTERN_W, incremented per sample, saturating at PATTERN_W.
REQ-016 SHALL encode y as: 2'b00 IDLE (fill=0), 2'b01 FILL (0<fill<PATTERN_W), 2'b10 ARMED (fill=PATTERN_W, no match), 2'b11 MATCH (match=1).
REQ-017 SHALL drive match=1 for exactly the one cycle after the edge whose sampled bit completes history==PATTERN with fill reaching PATTERN_W; latency 1 clock from sampling edge.
REQ-018 SHALL, in overlapping mode, keep history and fill after a match, so a suffix of the matched bits can start the next match.
REQ-019 SHALL, in non-overlapping mode, set fill to 0 on the matching edge, so the next match needs PATTERN_W fresh bits; y then reads 2'b11 for that cycle, then IDLE/FILL.
REQ-020 SHALL sample ovl_mode only on a matching edge; changes between matches take effect at the next match.
REQ-021 SHALL drive match=0 in any cycle following an edge with en=0; y SHALL show the held fill state.
REQ-022 SHALL increment count by 1 on each matching edge; at 2^CNT_W-1 count SHALL hold and cnt_sat SHALL be 1.
REQ-023 SHALL give clr_cnt priority over a simultaneous match: count=0, cnt_sat=0, the match pulse still asserts on match.
REQ-024 SHALL NOT let clr_cnt affect history, fill, match or y.

Reset
REQ-025 SHALL, on any rising edge with rst=1, set history=0, fill=0, y=2'b00, match=0, count=0, cnt_sat=0, regardless of en, x, clr_cnt.
REQ-026 SHALL, on reset mid-pattern, discard partial bits; detection restarts from IDLE on the first edge with rst=0 and en=1.

Structure
REQ-027 SHALL place the y status codes (IDLE, FILL, ARMED, MATCH) as named constants in a shared package pattern_detector_pkg.
REQ-028 SHALL implement count/cnt_sat as sub-module sat_counter (parameter CNT_W; inputs clk, rst, clr, inc; outputs count, sat).

Verification
REQ-029 SHALL check reset: rst=1 for 2 edges with x toggling -> y=00, match=0, count=0 on every cycle.
REQ-030 SHALL check overlap: ovl_mode=1, en=1, x=0,1,1,0,1,1,0 -> match pulses after the 4th and 7th bits, count=2, y=11 in both pulse cycles.
REQ-031 SHALL check non-overlap: ovl_mode=0, same stream -> one match after the 4th bit, count=1, y=01 after the 7th bit.
REQ-032 SHALL check enable gaps: bits 0,1 / en=0 for 3 cycles / bits 1,0 -> single match after the last bit, history unchanged during the gap.
REQ-033 SHALL check saturation and clear: CNT_W=2, 5 matches -> count=3, cnt_sat=1; clr_cnt with a matching edge -> count=0, match=1.
REQ-034 SHALL check mid-pattern reset: x=0,1,1, rst for 1 edge, then x=0 -> no match; then full 0,1,1,0 -> match.
